// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler: FSM state encodings and
// the helper that sizes the bit counter from the word width.
package serial_word_assembler_pkg;

  typedef enum logic {
    ST_HUNT     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } state_e;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register; each enabled cycle shifts d_in in at
// the LSB, so the first bit shifted in ends up at the MSB.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             d_in,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = {sr_q[WIDTH-2:0], d_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign par_out = sr_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Assembles MSB-first serial bits into WIDTH-bit words and offers them through
// a one-word valid/ready holding register with a sticky overrun flag.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int REQUIRE_SYNC = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        d_in,
  input  logic                        d_valid,
  input  logic                        frame_start,
  output logic [WIDTH-1:0]            word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        overrun,
  input  logic                        clear_ovr,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

  localparam int     CNT_W       = cnt_width(WIDTH);
  localparam state_e RESET_STATE = (REQUIRE_SYNC != 0) ? ST_HUNT : ST_ASSEMBLE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             complete;
  logic [WIDTH-1:0] par_out;
  logic [WIDTH-1:0] new_word;
  logic             sr_msb_unused;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .d_in     (d_in),
    .par_out  (par_out)
  );

  // The oldest bit in the shift register is already past the word boundary.
  assign new_word      = {par_out[WIDTH-2:0], d_in};
  assign sr_msb_unused = par_out[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_HUNT && frame_start) begin
      state_d = ST_ASSEMBLE;
    end
  end

  always_comb begin
    shift_en = d_valid && (state_q == ST_ASSEMBLE || frame_start);
    complete = d_valid && (state_q == ST_ASSEMBLE) && !frame_start &&
               (bit_cnt_q == CNT_W'(WIDTH - 1));
  end

  // frame_start restarts the count; stale bits age out of the shift register.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (frame_start) begin
      bit_cnt_d = d_valid ? CNT_W'(1) : '0;
    end else if (state_q == ST_ASSEMBLE && d_valid) begin
      bit_cnt_d = complete ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = clear_ovr ? 1'b0 : ovr_q;
    if (complete && (!valid_q || word_ready)) begin
      word_d  = new_word;
      valid_d = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler (WIDTH=8, REQUIRE_SYNC=1); a
// negedge monitor checks every transferred word against a queue of expected words.
module tb_serial_word_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_in = 1'b0;
  logic       d_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready = 1'b0;
  logic       overrun;
  logic       clear_ovr = 1'b0;
  logic [3:0] bit_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  serial_word_assembler #(.WIDTH(8), .REQUIRE_SYNC(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .d_valid     (d_valid),
    .frame_start (frame_start),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .overrun     (overrun),
    .clear_ovr   (clear_ovr),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs are applied just after a posedge, sampled on the next one.
  task automatic apply_stimulus(input logic fs, input logic dv, input logic b);
    frame_start = fs;
    d_valid     = dv;
    d_in        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic fs_first, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && rdy_last) word_ready = 1'b1;
      apply_stimulus((i == 7) ? fs_first : 1'b0, 1'b1, w[i]);
    end
    frame_start = 1'b0;
    d_valid     = 1'b0;
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge when both are high.
  always @(negedge clk) begin
    if (!rst && word_valid === 1'b1 && word_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %0h, expected no word", word_out);
      end else begin
        check_output("word_transfer", {24'd0, word_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] w;
    int         valid_seen;

    // Reset held for two cycles
    rst = 1'b1;
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 0);
    check_output("rst_word_out", {24'd0, word_out}, 32'h0);
    check_output("rst_word_valid", {31'd0, word_valid}, 32'h0);
    check_output("rst_overrun", {31'd0, overrun}, 32'h0);
    check_output("rst_bit_cnt", {28'd0, bit_cnt}, 32'h0);
    rst = 1'b0;

    // Bits in HUNT are ignored, then a framed 8'hA5
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1, i[0]);
    check_output("hunt_bit_cnt", {28'd0, bit_cnt}, 32'h0);
    check_output("hunt_word_valid", {31'd0, word_valid}, 32'h0);
    w = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = 7; i >= 1; i--) apply_stimulus((i == 7), 1, w[i]);
    check_output("a5_valid_before_last", {31'd0, word_valid}, 32'h0);
    apply_stimulus(0, 1, w[0]);
    check_output("a5_valid_after_last", {31'd0, word_valid}, 32'h1);
    check_output("a5_word_out", {24'd0, word_out}, 32'hA5);
    apply_stimulus(0, 0, 0);
    check_output("a5_valid_one_cycle", {31'd0, word_valid}, 32'h0);

    // Back-to-back words with no consumer: second is dropped
    word_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 1, 0);
    check_output("3c_valid", {31'd0, word_valid}, 32'h1);
    check_output("3c_overrun_pre", {31'd0, overrun}, 32'h0);
    send_word(8'hC3, 0, 0);
    check_output("c3_drop_word_out", {24'd0, word_out}, 32'h3C);
    check_output("c3_drop_overrun", {31'd0, overrun}, 32'h1);
    check_output("c3_drop_valid", {31'd0, word_valid}, 32'h1);
    clear_ovr = 1'b1;
    apply_stimulus(0, 0, 0);
    clear_ovr = 1'b0;
    check_output("clear_ovr", {31'd0, overrun}, 32'h0);
    word_ready = 1'b1;
    apply_stimulus(0, 0, 0);
    check_output("3c_drained", {31'd0, word_valid}, 32'h0);

    // Completion coincides with transfer of the held word
    word_ready = 1'b0;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    send_word(8'hF0, 1, 0);
    send_word(8'h0F, 0, 1);
    check_output("0f_word_out", {24'd0, word_out}, 32'h0F);
    check_output("0f_valid", {31'd0, word_valid}, 32'h1);
    check_output("0f_overrun", {31'd0, overrun}, 32'h0);
    apply_stimulus(0, 0, 0);
    check_output("0f_drained", {31'd0, word_valid}, 32'h0);

    // frame_start mid-word discards the partial
    word_ready = 1'b1;
    apply_stimulus(1, 1, 1);
    apply_stimulus(0, 1, 1);
    apply_stimulus(0, 1, 0);
    check_output("partial_bit_cnt", {28'd0, bit_cnt}, 32'h3);
    exp_q.push_back(8'h81);
    w = 8'h81;
    apply_stimulus(1, 1, w[7]);
    check_output("refs_bit_cnt", {28'd0, bit_cnt}, 32'h1);
    for (int i = 6; i >= 0; i--) apply_stimulus(0, 1, w[i]);
    check_output("81_word_out", {24'd0, word_out}, 32'h81);
    check_output("81_overrun", {31'd0, overrun}, 32'h0);
    apply_stimulus(0, 0, 0);

    // Reset mid-word returns to HUNT
    apply_stimulus(1, 1, 1);
    apply_stimulus(0, 1, 0);
    apply_stimulus(0, 1, 1);
    apply_stimulus(0, 1, 0);
    check_output("mid_bit_cnt", {28'd0, bit_cnt}, 32'h4);
    rst = 1'b1;
    apply_stimulus(0, 0, 0);
    rst = 1'b0;
    check_output("mid_rst_bit_cnt", {28'd0, bit_cnt}, 32'h0);
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 1, 1);
      if (word_valid !== 1'b0) valid_seen++;
    end
    apply_stimulus(0, 0, 0);
    check_output("post_rst_no_word", valid_seen, 32'h0);
    check_output("post_rst_bit_cnt", {28'd0, bit_cnt}, 32'h0);

    check_output("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
